keypad_entry: RTL

- Multi-digit keypad entry controller; parametrised successor to the team's single-register keypad capture.
- Sits between the keypad scanner (raw key code plus bouncy key-down level) and downstream arithmetic/display logic.
- Synchronises and debounces key presses, then shifts decimal digits into a DIGITS-wide BCD buffer.
- Implements backspace, clear and enter commands; enter latches a committed value with a one-cycle strobe.

---
 rtl/keypad_entry.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: multi-digit keypad entry controller.
//   Synchronises and debounces a raw keypad scanner, then applies one action per press:
//   digits 0-9 shift into a BCD buffer, 0xA commits the buffer (enter), 0xB removes the
//   newest digit (backspace), 0xC clears the buffer, 0xD-0xF are ignored.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   key_value    raw scanner key code (unsynchronised)
//   key_down     raw scanner key-pressed level (unsynchronised, bouncy)
//   out          live entry buffer, newest digit in [3:0]
//   count        number of digits in the buffer
//   value        last committed entry
//   value_valid  one-cycle pulse when value updates
//   overflow     sticky: a digit was dropped because the buffer was full
//   key_strobe   one-cycle pulse on every accepted press
module keypad_entry #(
   parameter int unsigned DIGITS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CW              = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            key_value,
   input  logic                  key_down,
   output logic [DIGITS*4-1:0]   out,
   output logic [CW-1:0]         count,
   output logic [DIGITS*4-1:0]   value,
   output logic                  value_valid,
   output logic                  overflow,
   output logic                  key_strobe
);

   localparam int unsigned W   = DIGITS * 4;
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StPressDb, StHeld, StReleaseDb} state_e;

   state_e         state_q, state_d;
   logic           kd_s1_q, kd_s1_d, kd_s2_q, kd_s2_d;
   logic [3:0]     kv_s1_q, kv_s1_d, kv_s2_q, kv_s2_d;
   logic [1:0]     prime_q, prime_d;
   logic           armed_q, armed_d;
   logic [DBW-1:0] cnt_q, cnt_d;
   logic [3:0]     cand_q, cand_d;
   logic [W-1:0]   out_q, out_d, value_q, value_d;
   logic [CW-1:0]  count_q, count_d;
   logic           value_valid_q, value_valid_d;
   logic           overflow_q, overflow_d;
   logic           key_strobe_q, key_strobe_d;
   logic           fire;
   logic           cnt_done;

   // Synchronisers, plus a priming shift register that marks when kd_s2_q holds a real sample.
   always_comb begin
      kd_s1_d = key_down;
      kd_s2_d = kd_s1_q;
      kv_s1_d = key_value;
      kv_s2_d = kv_s1_q;
      prime_d = {prime_q[0], 1'b1};
   end

   // Debounce FSM. A key held across reset is not accepted until it has been seen released:
   // armed_q only rises once the primed synchroniser reports key_down low.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cand_d   = cand_q;
      fire     = 1'b0;
      armed_d  = armed_q | (prime_q[1] & ~kd_s2_q);
      cnt_done = (cnt_q + DBW'(1)) == DBW'(DEBOUNCE_CYCLES);
      case (state_q)
         StIdle: begin
            if (kd_s2_q && armed_q) begin
               cand_d = kv_s2_q;
               cnt_d  = DBW'(1);
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = StHeld;
                  fire    = 1'b1;
               end else begin
                  state_d = StPressDb;
               end
            end
         end
         StPressDb: begin
            if (!kd_s2_q) begin
               state_d = StIdle;
            end else if (kv_s2_q != cand_q) begin
               cand_d = kv_s2_q;
               cnt_d  = DBW'(1);
            end else begin
               cnt_d = cnt_q + DBW'(1);
               if (cnt_done) begin
                  state_d = StHeld;
                  fire    = 1'b1;
               end
            end
         end
         StHeld: begin
            if (!kd_s2_q) begin
               cnt_d   = DBW'(1);
               state_d = (DEBOUNCE_CYCLES == 1) ? StIdle : StReleaseDb;
            end
         end
         StReleaseDb: begin
            if (kd_s2_q) begin
               state_d = StHeld;
            end else begin
               cnt_d = cnt_q + DBW'(1);
               if (cnt_done) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Key actions, applied on the edge the press is accepted.
   always_comb begin
      out_d         = out_q;
      count_d       = count_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      overflow_d    = overflow_q;
      key_strobe_d  = fire;
      if (fire) begin
         if (cand_d <= 4'h9) begin
            if (count_q < CW'(DIGITS)) begin
               // Shift form keeps DIGITS=1 legal: out_q << 4 is all zeros there.
               out_d   = (out_q << 4) | W'(cand_d);
               count_d = count_q + CW'(1);
            end else begin
               overflow_d = 1'b1;
            end
         end else begin
            case (cand_d)
               4'hA: begin
                  if (count_q != '0) begin
                     value_d       = out_q;
                     value_valid_d = 1'b1;
                     out_d         = '0;
                     count_d       = '0;
                     overflow_d    = 1'b0;
                  end
               end
               4'hB: begin
                  if (count_q != '0) begin
                     out_d      = out_q >> 4;
                     count_d    = count_q - CW'(1);
                     overflow_d = 1'b0;
                  end
               end
               4'hC: begin
                  out_d      = '0;
                  count_d    = '0;
                  overflow_d = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kd_s1_q       <= 1'b0;
         kd_s2_q       <= 1'b0;
         kv_s1_q       <= '0;
         kv_s2_q       <= '0;
         prime_q       <= '0;
         armed_q       <= 1'b0;
         state_q       <= StIdle;
         cnt_q         <= '0;
         cand_q        <= '0;
         out_q         <= '0;
         count_q       <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         key_strobe_q  <= 1'b0;
      end else begin
         kd_s1_q       <= kd_s1_d;
         kd_s2_q       <= kd_s2_d;
         kv_s1_q       <= kv_s1_d;
         kv_s2_q       <= kv_s2_d;
         prime_q       <= prime_d;
         armed_q       <= armed_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_q        <= cand_d;
         out_q         <= out_d;
         count_q       <= count_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         overflow_q    <= overflow_d;
         key_strobe_q  <= key_strobe_d;
      end
   end

   assign out         = out_q;
   assign count       = count_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign overflow    = overflow_q;
   assign key_strobe  = key_strobe_q;

endmodule
